// File: rtl/tinyalu_core_if.sv
// TinyALU command bus: operands, opcode and start from the initiator,
// done/result back from the ALU.
interface tinyalu_core_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0]   A;
    logic [DATA_W-1:0]   B;
    logic [2:0]          op;
    logic                start;
    logic                done;
    logic [2*DATA_W-1:0] result;

    modport master (
        output A, B, op, start,
        input  done, result
    );

    modport slave (
        input  A, B, op, start,
        output done, result
    );
endinterface

// File: rtl/tinyalu_core.sv
// TinyALU responder: single-cycle add/and/xor, iterative shift-add multiply,
// one-cycle done pulse and a HOLD state so a held start never re-triggers.
module tinyalu_core #(
    parameter int DATA_W = 8
) (
    input  logic          clk,
    input  logic          reset,
    tinyalu_core_if.slave bus
);
    localparam int RES_W = 2 * DATA_W;
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ALU  = 2'd1;
    localparam logic [1:0] MUL  = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [RES_W-1:0]  mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [RES_W-1:0]  prod_q, prod_d;
    logic [RES_W-1:0]  result_q, result_d;
    logic              done_q, done_d;
    logic [RES_W-1:0]  sum;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        result_d = result_q;
        done_d   = 1'b0;
        // Partial product for the current multiplier bit.
        sum      = prod_q + (mplier_q[0] ? mcand_q : '0);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d      = bus.A;
                    b_d      = bus.B;
                    op_d     = bus.op;
                    mcand_d  = {{DATA_W{1'b0}}, bus.A};
                    mplier_d = bus.B;
                    prod_d   = '0;
                    cnt_d    = '0;
                    state_d  = (bus.op == OP_MUL) ? MUL : ALU;
                end
            end
            ALU: begin
                done_d  = 1'b1;
                state_d = HOLD;
                unique case (1'b1)
                    (op_q == OP_NOP): result_d = result_q;
                    (op_q == OP_ADD): result_d = RES_W'({1'b0, a_q} + {1'b0, b_q});
                    (op_q == OP_AND): result_d = RES_W'(a_q & b_q);
                    (op_q == OP_XOR): result_d = RES_W'(a_q ^ b_q);
                    default:          result_d = '0;
                endcase
            end
            MUL: begin
                prod_d   = sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    result_d = sum;
                    done_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (!bus.start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_tinyalu_core.sv
// Bench for tinyalu_core: vector table plus hand-written corner sequences,
// results checked through a queue as done pulses appear.
module tb_tinyalu_core;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   fails = 0;
    int   done_cnt = 0;
    int   cyc = 0;
    int   done_cyc = 0;
    logic [15:0] exp_q[$];

    tinyalu_core_if #(.DATA_W(8)) bus ();

    tinyalu_core #(.DATA_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
        int          lat;
        int          hold;
    } vec_t;

    vec_t tbl[10];

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(bus.result), 32'hDEAD_BEEF);
            end else begin
                chk("result", 32'(bus.result), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic issue(input string nm, input logic [2:0] op,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp, input int lat,
                         input int hold);
        int n;
        bit got;
        int d0;
        d0 = done_cnt;
        bus.A = a;
        bus.B = b;
        bus.op = op;
        bus.start = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        n = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            got = (bus.done === 1'b1);
        end
        done_cyc = cyc;
        chk({nm, "_latency"}, 32'(n), 32'(lat));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk({nm, "_no_repulse"}, 32'(bus.done), 32'd0);
        end
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        chk({nm, "_pulses"}, 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit got;
        int d0;
        int first_done;

        tbl[0] = '{3'b001, 8'hFF, 8'h01, 16'h0100, 1, 3};
        tbl[1] = '{3'b100, 8'hFF, 8'hFF, 16'hFE01, 8, 1};
        tbl[2] = '{3'b100, 8'h00, 8'h37, 16'h0000, 8, 0};
        tbl[3] = '{3'b011, 8'hA5, 8'h0F, 16'h00AA, 1, 0};
        tbl[4] = '{3'b000, 8'h12, 8'h34, 16'h00AA, 1, 0};
        tbl[5] = '{3'b111, 8'h12, 8'h34, 16'h0000, 1, 0};
        tbl[6] = '{3'b010, 8'hC3, 8'h5A, 16'h0042, 1, 2};
        tbl[7] = '{3'b001, 8'h80, 8'h80, 16'h0100, 1, 0};
        tbl[8] = '{3'b100, 8'h0D, 8'h0B, 16'h008F, 8, 0};
        tbl[9] = '{3'b101, 8'hFF, 8'hFF, 16'h0000, 1, 0};

        bus.A = '0;
        bus.B = '0;
        bus.op = '0;
        bus.start = 1'b0;

        @(posedge clk);
        #1;
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_result", 32'(bus.result), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            issue($sformatf("v%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                  tbl[i].exp, tbl[i].lat, tbl[i].hold);
        end

        // Mul with start dropped after accept and inputs scrambled.
        d0 = done_cnt;
        bus.A = 8'h12;
        bus.B = 8'h34;
        bus.op = 3'b100;
        bus.start = 1'b1;
        exp_q.push_back(16'h03A8);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            bus.A = 8'($urandom);
            bus.B = 8'($urandom);
            bus.op = 3'($urandom);
            @(posedge clk);
            #1;
            n++;
            got = (bus.done === 1'b1);
        end
        chk("drop_latency", 32'(n), 32'd8);
        repeat (3) @(posedge clk);
        #1;
        chk("drop_pulses", 32'(done_cnt - d0), 32'd1);
        chk("drop_result_hold", 32'(bus.result), 32'h03A8);

        // Reset in the fourth cycle of a multiply.
        d0 = done_cnt;
        bus.A = 8'hFF;
        bus.B = 8'hFF;
        bus.op = 3'b100;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("abort_result", 32'(bus.result), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        issue("after_abort", 3'b010, 8'hF0, 8'h3C, 16'h0030, 1, 0);

        // Back-to-back with start low for exactly one cycle.
        issue("b2b_add", 3'b001, 8'h10, 8'h20, 16'h0030, 1, 0);
        first_done = done_cyc;
        issue("b2b_and", 3'b010, 8'hFF, 8'h0F, 16'h000F, 1, 0);
        chk("b2b_gap", 32'(done_cyc - first_done), 32'd3);

        repeat (2) @(posedge clk);
        #1;
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end
endmodule
